// File: rtl/mem_wb_if.sv
// M-to-W pipeline boundary: M-stage operands and hazard controls flow in,
// register-file writeback and retirement count flow out.
interface mem_wb_if #(
  parameter int DATA_WIDTH             = 32,
  parameter int REG_FILE_ADDRESS_WIDTH = 5,
  parameter int COUNT_WIDTH            = 64
);
  logic                              ValidM;
  logic [DATA_WIDTH-1:0]             ALUResultM;
  logic [DATA_WIDTH-1:0]             ReadDataM;
  logic [DATA_WIDTH-1:0]             PCPlus4M;
  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM;
  logic                              RegWriteM;
  logic [1:0]                        ResultSrcM;
  logic                              StallW;
  logic                              FlushW;

  logic [DATA_WIDTH-1:0]             ResultW;
  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW;
  logic                              RegWriteW;
  logic                              ValidW;
  logic [COUNT_WIDTH-1:0]            RetiredCountW;

  modport master (
    output ValidM, ALUResultM, ReadDataM, PCPlus4M, RdM, RegWriteM, ResultSrcM,
           StallW, FlushW,
    input  ResultW, RdW, RegWriteW, ValidW, RetiredCountW
  );

  modport slave (
    input  ValidM, ALUResultM, ReadDataM, PCPlus4M, RdM, RegWriteM, ResultSrcM,
           StallW, FlushW,
    output ResultW, RdW, RegWriteW, ValidW, RetiredCountW
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback result select, x0 write
// suppression and a wrapping retired-instruction counter.
module mem_wb_stage #(
  parameter int DATA_WIDTH             = 32,
  parameter int REG_FILE_ADDRESS_WIDTH = 5,
  parameter int COUNT_WIDTH            = 64
) (
  input logic      clk,
  input logic      rst,
  mem_wb_if.slave  bus
);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_MEM  = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_RSVD = 2'b11
  } result_src_t;

  logic                              valid_q;
  logic [DATA_WIDTH-1:0]             alu_q;
  logic [DATA_WIDTH-1:0]             rdata_q;
  logic [DATA_WIDTH-1:0]             pc4_q;
  logic [REG_FILE_ADDRESS_WIDTH-1:0] rd_q;
  logic                              regwrite_q;
  result_src_t                       src_q;
  logic [COUNT_WIDTH-1:0]            count_q;
  logic [DATA_WIDTH-1:0]             result;
  logic                              retire;

  // The W occupant retires on any unstalled edge, even one that flushes it.
  assign retire = valid_q & ~bus.StallW;

  // W registers: flush beats stall beats capture; bubbles are captured too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      src_q      <= SRC_ALU;
    end else if (bus.FlushW) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      src_q      <= SRC_ALU;
    end else if (!bus.StallW) begin
      valid_q    <= bus.ValidM;
      alu_q      <= bus.ALUResultM;
      rdata_q    <= bus.ReadDataM;
      pc4_q      <= bus.PCPlus4M;
      rd_q       <= bus.RdM;
      regwrite_q <= bus.RegWriteM;
      src_q      <= result_src_t'(bus.ResultSrcM);
    end
  end

  // Retirement counter, wraps silently at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  // Writeback data select from stored operands only; reserved encoding yields zero.
  always_comb begin
    result = '0;
    case (src_q)
      SRC_ALU:  result = alu_q;
      SRC_MEM:  result = rdata_q;
      SRC_PC4:  result = pc4_q;
      SRC_RSVD: result = '0;
      default:  result = '0;
    endcase
  end

  assign bus.ResultW       = result;
  assign bus.RdW           = rd_q;
  assign bus.ValidW        = valid_q;
  assign bus.RegWriteW     = regwrite_q & valid_q & (rd_q != '0);
  assign bus.RetiredCountW = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a default-width instance and a 4-bit-counter
// instance share one stimulus stream and are compared to a record-level model.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        validm = 1'b0;
  logic [31:0] alum   = '0;
  logic [31:0] readm  = '0;
  logic [31:0] pc4m   = '0;
  logic [4:0]  rdm    = '0;
  logic        regwm  = 1'b0;
  logic [1:0]  srcm   = '0;
  logic        stallw = 1'b0;
  logic        flushw = 1'b0;

  mem_wb_if #(.DATA_WIDTH(32), .REG_FILE_ADDRESS_WIDTH(5), .COUNT_WIDTH(64)) b64 ();
  mem_wb_if #(.DATA_WIDTH(32), .REG_FILE_ADDRESS_WIDTH(5), .COUNT_WIDTH(4))  b4 ();

  assign b64.ValidM = validm;  assign b4.ValidM = validm;
  assign b64.ALUResultM = alum; assign b4.ALUResultM = alum;
  assign b64.ReadDataM = readm; assign b4.ReadDataM = readm;
  assign b64.PCPlus4M = pc4m;  assign b4.PCPlus4M = pc4m;
  assign b64.RdM = rdm;        assign b4.RdM = rdm;
  assign b64.RegWriteM = regwm; assign b4.RegWriteM = regwm;
  assign b64.ResultSrcM = srcm; assign b4.ResultSrcM = srcm;
  assign b64.StallW = stallw;  assign b4.StallW = stallw;
  assign b64.FlushW = flushw;  assign b4.FlushW = flushw;

  mem_wb_stage #(.DATA_WIDTH(32), .REG_FILE_ADDRESS_WIDTH(5), .COUNT_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .bus(b64.slave)
  );
  mem_wb_stage #(.DATA_WIDTH(32), .REG_FILE_ADDRESS_WIDTH(5), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave)
  );

  // Model: the instruction sitting in W as a record, plus a plain retire tally.
  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  src;
  } rec_t;

  rec_t        m_w;
  logic [63:0] m_count;

  function automatic logic [31:0] exp_result(input rec_t r);
    if (r.src == 2'd0) return r.alu;
    if (r.src == 2'd1) return r.rdata;
    if (r.src == 2'd2) return r.pc4;
    return 32'd0;
  endfunction

  function automatic logic exp_write(input rec_t r);
    return r.rw && r.valid && (r.rd != 5'd0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_w     <= '0;
      m_count <= '0;
    end else begin
      if (m_w.valid && !stallw) m_count <= m_count + 64'd1;
      if (flushw)       m_w <= '0;
      else if (!stallw) m_w <= '{validm, alum, readm, pc4m, rdm, regwm, srcm};
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic cyc(input logic v, input logic [31:0] alu, input logic [31:0] rdat,
                     input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                     input logic [1:0] src, input logic st, input logic fl);
    @(negedge clk);
    validm = v; alum = alu; readm = rdat; pc4m = pc4;
    rdm = rd; regwm = rw; srcm = src; stallw = st; flushw = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("cmp_result",   b64.ResultW,       exp_result(m_w));
      check("cmp_rd",       b64.RdW,           m_w.rd);
      check("cmp_valid",    b64.ValidW,        m_w.valid);
      check("cmp_regwrite", b64.RegWriteW,     exp_write(m_w));
      check("cmp_count",    b64.RetiredCountW, m_count);
      check("cmp_count4",   b4.RetiredCountW,  {60'd0, m_count[3:0]});
    end
  endtask

  task automatic directed();
    // reset and idle
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) bubble();
    check("idle_count", b64.RetiredCountW, 64'd0);
    check("idle_valid", b64.ValidW, 64'd0);

    // result select
    cyc(1'b1, 32'h10, 32'h20, 32'h30, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0);
    check("sel_alu", b64.ResultW, 64'h10);
    check("sel_alu_we", b64.RegWriteW, 64'd1);
    check("sel_alu_rd", b64.RdW, 64'd5);
    check("sel_alu_cnt", b64.RetiredCountW, 64'd0);
    cyc(1'b1, 32'h10, 32'h20, 32'h30, 5'd5, 1'b1, 2'd1, 1'b0, 1'b0);
    check("sel_mem", b64.ResultW, 64'h20);
    check("sel_mem_cnt", b64.RetiredCountW, 64'd1);
    cyc(1'b1, 32'h10, 32'h20, 32'h30, 5'd5, 1'b1, 2'd2, 1'b0, 1'b0);
    check("sel_pc4", b64.ResultW, 64'h30);
    check("sel_pc4_cnt", b64.RetiredCountW, 64'd2);
    cyc(1'b1, 32'h10, 32'h20, 32'h30, 5'd5, 1'b1, 2'd3, 1'b0, 1'b0);
    check("sel_rsvd", b64.ResultW, 64'h0);
    check("sel_rsvd_we", b64.RegWriteW, 64'd1);
    check("sel_rsvd_cnt", b64.RetiredCountW, 64'd3);

    // x0 target and bubble
    cyc(1'b1, 32'h10, 32'h20, 32'h30, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0);
    check("x0_we", b64.RegWriteW, 64'd0);
    check("x0_valid", b64.ValidW, 64'd1);
    check("x0_cnt", b64.RetiredCountW, 64'd4);
    cyc(1'b0, 32'h10, 32'h20, 32'h30, 5'd7, 1'b1, 2'd0, 1'b0, 1'b0);
    check("bub_we", b64.RegWriteW, 64'd0);
    check("bub_rd", b64.RdW, 64'd7);
    check("bub_cnt", b64.RetiredCountW, 64'd5);
    bubble();
    check("bub_cnt2", b64.RetiredCountW, 64'd5);

    // stall holds everything and defers retirement
    cyc(1'b1, 32'hAA, 32'hBB, 32'hCC, 5'd3, 1'b1, 2'd0, 1'b0, 1'b0);
    check("stl_load", b64.ResultW, 64'hAA);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h100 + i, 32'h200, 32'h300, 5'd9, 1'b0, 2'd1, 1'b1, 1'b0);
      check("stl_hold_res", b64.ResultW, 64'hAA);
      check("stl_hold_rd", b64.RdW, 64'd3);
      check("stl_hold_cnt", b64.RetiredCountW, 64'd5);
    end
    bubble();
    check("stl_rel_cnt", b64.RetiredCountW, 64'd6);
    check("stl_rel_valid", b64.ValidW, 64'd0);
    bubble();
    check("stl_once", b64.RetiredCountW, 64'd6);

    // flush, and flush together with stall
    cyc(1'b1, 32'h55, 32'h0, 32'h0, 5'd4, 1'b1, 2'd0, 1'b0, 1'b1);
    check("fl_valid", b64.ValidW, 64'd0);
    check("fl_we", b64.RegWriteW, 64'd0);
    check("fl_res", b64.ResultW, 64'd0);
    check("fl_rd", b64.RdW, 64'd0);
    cyc(1'b1, 32'h66, 32'h0, 32'h0, 5'd6, 1'b1, 2'd0, 1'b0, 1'b0);
    check("fl_next", b64.ResultW, 64'h66);
    cyc(1'b1, 32'h77, 32'h0, 32'h0, 5'd8, 1'b1, 2'd0, 1'b1, 1'b1);
    check("flst_valid", b64.ValidW, 64'd0);
    check("flst_cnt", b64.RetiredCountW, 64'd6);
    bubble();
    check("flst_cnt2", b64.RetiredCountW, 64'd6);

    // asynchronous reset while stalling and flushing
    cyc(1'b1, 32'h99, 32'h0, 32'h0, 5'd2, 1'b1, 2'd0, 1'b0, 1'b0);
    check("ar_pre_cnt", b64.RetiredCountW, 64'd6);
    @(negedge clk);
    stallw = 1'b1; flushw = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("ar_res", b64.ResultW, 64'd0);
    check("ar_rd", b64.RdW, 64'd0);
    check("ar_we", b64.RegWriteW, 64'd0);
    check("ar_valid", b64.ValidW, 64'd0);
    check("ar_cnt", b64.RetiredCountW, 64'd0);
    check("ar_cnt4", b4.RetiredCountW, 64'd0);
    @(negedge clk);
    rst = 1'b0; stallw = 1'b0; flushw = 1'b0; validm = 1'b0;

    // counter wrap on the 4-bit instance
    for (int i = 1; i <= 17; i++) begin
      cyc(1'b1, 32'(i), 32'h0, 32'h0, 5'd1, 1'b1, 2'd0, 1'b0, 1'b0);
      if (i == 16) check("wrap_15", b4.RetiredCountW, 64'd15);
      if (i == 17) check("wrap_0", b4.RetiredCountW, 64'd0);
    end
    bubble();
    check("wrap_1", b4.RetiredCountW, 64'd1);
    check("wrap_wide", b64.RetiredCountW, 64'd17);
    @(negedge clk);
  endtask

  initial begin
    fork
      compare_loop();
      directed();
      begin
        #100000;
        n_checks++;
        $display("FAIL watchdog actual=timeout required=completion");
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath width of results and addresses.
REQ-002 Parameter REG_FILE_ADDRESS_WIDTH, default 5, destination register index width.
REQ-003 Parameter COUNT_WIDTH, default 64, retired-instruction counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ValidM  input  1  M-stage holds a real instruction (0 = bubble).
REQ-007 ALUResultM  input  DATA_WIDTH  ALU result / effective address from M stage.
REQ-008 ReadDataM  input  DATA_WIDTH  load data returned by the M-stage data memory, already extended.
REQ-009 PCPlus4M  input  DATA_WIDTH  return address for JAL/JALR.
REQ-010 RdM  input  REG_FILE_ADDRESS_WIDTH  destination register index.
REQ-011 RegWriteM  input  1  instruction writes the register file.
REQ-012 ResultSrcM  input  2  result select: 00 ALU, 01 memory, 10 PC+4, 11 reserved.
REQ-013 StallW  input  1  hold W-stage contents.
REQ-014 FlushW  input  1  replace W-stage contents with a bubble.
REQ-015 ResultW  output  DATA_WIDTH  register-file write data.
REQ-016 RdW  output  REG_FILE_ADDRESS_WIDTH  register-file write index.
REQ-017 RegWriteW  output  1  qualified register-file write enable.
REQ-018 ValidW  output  1  W stage holds a real instruction.
REQ-019 RetiredCountW  output  COUNT_WIDTH  count of instructions retired since reset.

Function
REQ-020 Internal W registers SHALL hold ValidM, ALUResultM, ReadDataM, PCPlus4M, RdM, RegWriteM and ResultSrcM.
REQ-021 Latency SHALL be exactly one cycle: M-stage values captured at edge N appear on W outputs after edge N.
REQ-022 Priority at each edge SHALL be: rst (async), then FlushW, then StallW, then normal capture.
REQ-023 FlushW=1 SHALL clear the valid bit and the RegWrite bit; the other W registers are don't-care and SHALL be cleared to 0.
REQ-024 StallW=1 with FlushW=0 SHALL hold every W register unchanged.
REQ-025 Normal capture SHALL load all W registers from the M-stage inputs, including when ValidM=0.
REQ-026 ResultW SHALL be combinational from the W registers: 00 ALU result, 01 read data, 10 PC+4, 11 all zeros.
REQ-027 RegWriteW SHALL equal stored RegWrite AND ValidW AND (RdW != 0), so writes to x0 are never issued.
REQ-028 RdW and ValidW SHALL be driven directly from the W registers.
REQ-029 An instruction retires on a rising edge where ValidW=1, StallW=0 and rst=0, regardless of FlushW.
REQ-030 RetiredCountW SHALL increment by 1 on each retirement.
REQ-031 RetiredCountW SHALL wrap modulo 2^COUNT_WIDTH: all ones plus 1 gives 0, with no flag.
REQ-032 A stalled valid instruction SHALL retire exactly once, on the first unstalled edge.
REQ-033 Simultaneous FlushW and StallW SHALL flush. A valid instruction present on that edge SHALL NOT be counted, because StallW=1.
REQ-034 The block SHALL contain no combinational path from the M-stage inputs to any output.

Reset
REQ-035 rst=1 SHALL immediately, without waiting for a clock edge, clear every W register and RetiredCountW to 0.
REQ-036 During reset ResultW=0, RdW=0, RegWriteW=0 and ValidW=0.
REQ-037 Reset asserted mid-stall or mid-flush SHALL override both; the first capture occurs on the first edge after rst deasserts.

Verification
REQ-038 Reset: assert rst between edges -> all outputs 0 before the next edge; after release with ValidM=0 for 3 cycles, RetiredCountW stays 0.
REQ-039 Result select: Valid=1, Rd=5, RegWrite=1, ALU=0x10, Read=0x20, PC+4=0x30, ResultSrc=00/01/10/11 -> ResultW = 0x10/0x20/0x30/0x0 one cycle later, RegWriteW=1, and the count increments each cycle.
REQ-040 x0 and bubble: Rd=0, RegWrite=1, Valid=1 -> RegWriteW=0 and the count still increments; Valid=0, Rd=7 -> RegWriteW=0 and the count does not increment.
REQ-041 Stall: capture a valid instruction, then StallW=1 for 3 cycles while inputs change -> outputs frozen and the count unchanged; on release the count increases by exactly 1.
REQ-042 Flush: FlushW=1 with a valid instruction in M -> next cycle ValidW=0 and RegWriteW=0; FlushW=1 and StallW=1 together -> flush wins and there is no increment.
REQ-043 Wrap: COUNT_WIDTH=4, retire 17 valid instructions from reset -> RetiredCountW reads 15 after 15 retirements, 0 after 16, and 1 after 17.
